// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares one fixed-latency instruction-ROM read port between fetch and load paths
//
// Purpose:
//   Arbitrates the instruction-fetch path (IF) and a constant-load path (LS) onto a
//   single ROM read port. One access is outstanding at a time. Each access runs
//   IDLE (accept) -> ISSUE (rom_en) -> WAIT (ROM_LATENCY cycles) -> IDLE, and the
//   returned word is steered into the owner's rdata register with a one-cycle rvalid.
//   LS wins by default; after STARVE_LIMIT consecutive LS wins against a waiting IF,
//   IF is forced through. A branch flush kills an in-flight fetch so its stale word
//   is never delivered.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   if_req/if_addr/if_gnt     fetch request, address, combinational accept
//   if_flush                  discard the in-flight fetch, if any
//   if_rvalid/if_rdata        fetch return pulse and held word
//   ls_req/ls_addr/ls_gnt     load request, address, combinational accept
//   ls_rvalid/ls_rdata        load return pulse and held word
//   rom_addr/rom_en/rom_data  external ROM pins (rom_addr registered)
//   busy                      high whenever the FSM is not IDLE

module rom_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ROM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LAST   = 3'(ROM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state;
  logic       owner_ls;    // 1: LS owns the in-flight access, 0: IF owns it
  logic       kill;        // in-flight fetch was flushed; drop its data
  logic [2:0] lat_cnt;
  logic [3:0] starve_cnt;  // consecutive LS wins while IF was waiting
  logic       starved;

  assign starved = (starve_cnt >= STARVE_MAX);
  assign busy    = (state != S_IDLE);

  // Grants are only offered in IDLE and are suppressed while reset is held so
  // every output reads 0 during reset.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst && state == S_IDLE) begin
      if (ls_req && !(if_req && starved)) begin
        ls_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner_ls   <= 1'b0;
      kill       <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      rom_addr   <= '0;
      rom_en     <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
    end else begin
      // Pulses default low; rom_en is only ever high during ISSUE.
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      rom_en    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (if_gnt) begin
            rom_addr <= if_addr;
            owner_ls <= 1'b0;
          end else if (ls_gnt) begin
            rom_addr <= ls_addr;
            owner_ls <= 1'b1;
          end
          if (if_gnt || ls_gnt) begin
            kill   <= 1'b0;  // a flush in the accept cycle does not hit the new fetch
            rom_en <= 1'b1;
            state  <= S_ISSUE;
          end
          // An idle IF (or an IF win) resets the fairness window; an LS win
          // over a waiting IF extends it.
          if (!if_req || if_gnt) begin
            starve_cnt <= '0;
          end else if (ls_gnt) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end

        S_ISSUE: begin
          if (if_flush && !owner_ls) begin
            kill <= 1'b1;
          end
          lat_cnt <= '0;
          state   <= S_WAIT;
        end

        S_WAIT: begin
          if (if_flush && !owner_ls) begin
            kill <= 1'b1;
          end
          if (lat_cnt == LAT_LAST) begin
            state <= S_IDLE;
            if (owner_ls) begin
              ls_rdata  <= rom_data;
              ls_rvalid <= 1'b1;
            end else if (!(kill || if_flush)) begin
              // A flush in the capture cycle itself must also drop the word,
              // before the kill flag has had a chance to register.
              if_rdata  <= rom_data;
              if_rvalid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - self-checking bench for rom_port_arbiter (latency 1 and latency 3 instances)

module tb_rom_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, ls_req;
  logic [AW-1:0] if_addr, ls_addr;

  logic          if_gnt1, if_rvalid1, ls_gnt1, ls_rvalid1, rom_en1, busy1;
  logic [DW-1:0] if_rdata1, ls_rdata1, rom_data1;
  logic [AW-1:0] rom_addr1;

  logic          if_gnt3, if_rvalid3, ls_gnt3, ls_rvalid3, rom_en3, busy3;
  logic [DW-1:0] if_rdata3, ls_rdata3, rom_data3;
  logic [AW-1:0] rom_addr3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1), .STARVE_LIMIT(LIM)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_flush(if_flush),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt1),
    .ls_rvalid(ls_rvalid1), .ls_rdata(ls_rdata1),
    .rom_addr(rom_addr1), .rom_en(rom_en1), .rom_data(rom_data1), .busy(busy1)
  );

  rom_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(3), .STARVE_LIMIT(LIM)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_flush(if_flush),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt3),
    .ls_rvalid(ls_rvalid3), .ls_rdata(ls_rdata3),
    .rom_addr(rom_addr3), .rom_en(rom_en3), .rom_data(rom_data3), .busy(busy3)
  );

  // ROM contents: 0x10 holds the first test instruction, everything else a scramble of the address.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  // ROM models: data appears ROM_LATENCY cycles after the rom_en cycle, junk otherwise.
  logic [DW-1:0] q1;
  logic [DW-1:0] s3 [0:2];
  always @(posedge clk) begin
    q1    <= rom_en1 ? rom_word(rom_addr1) : (32'hBAD0_0000 | 32'($urandom_range(0, 65535)));
    s3[0] <= rom_en3 ? rom_word(rom_addr3) : (32'hBAD3_0000 | 32'($urandom_range(0, 65535)));
    s3[1] <= s3[0];
    s3[2] <= s3[1];
  end
  assign rom_data1 = q1;
  assign rom_data3 = s3[2];

  task automatic idle_in();
    if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
  endtask

  task automatic drain(input int n);
    idle_in();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_in(); if_addr = '0; ls_addr = '0;
    repeat (2) @(negedge clk);
    if_req = 1'b1; ls_req = 1'b1;
    #1;
    n_total++; if ({rom_en1, busy1, if_rvalid1, ls_rvalid1, if_gnt1, ls_gnt1} !== 6'b0) $display("FAIL reset_ctrl1: got %b want 000000", {rom_en1, busy1, if_rvalid1, ls_rvalid1, if_gnt1, ls_gnt1}); else n_pass++;
    n_total++; if ({rom_addr1, if_rdata1, ls_rdata1} !== 96'b0) $display("FAIL reset_data1: got %h want 0", {rom_addr1, if_rdata1, ls_rdata1}); else n_pass++;
    n_total++; if ({rom_addr3, if_rdata3, ls_rdata3, rom_en3, busy3, if_rvalid3, ls_rvalid3, if_gnt3, ls_gnt3} !== 102'b0) $display("FAIL reset_all3: got %h want 0", {rom_addr3, if_rdata3, ls_rdata3, rom_en3, busy3, if_rvalid3, ls_rvalid3, if_gnt3, ls_gnt3}); else n_pass++;
    @(negedge clk);
    rst = 1'b0; idle_in();
  endtask

  task automatic test_single_fetch();
    @(negedge clk); if_req = 1'b1; if_addr = 32'h10; #1;
    n_total++; if ({if_gnt1, ls_gnt1, busy1} !== 3'b100) $display("FAIL single_gnt: got %b want 100", {if_gnt1, ls_gnt1, busy1}); else n_pass++;
    @(negedge clk); idle_in(); #1;
    n_total++; if ({rom_en1, busy1} !== 2'b11 || rom_addr1 !== 32'h10) $display("FAIL single_issue: got en/busy %b addr %h want 11 00000010", {rom_en1, busy1}, rom_addr1); else n_pass++;
    @(negedge clk); #1;
    n_total++; if ({rom_en1, busy1, if_rvalid1} !== 3'b010 || rom_data1 !== 32'h0050_0093) $display("FAIL single_wait: got %b data %h want 010 00500093", {rom_en1, busy1, if_rvalid1}, rom_data1); else n_pass++;
    @(negedge clk); #1;
    n_total++; if ({if_rvalid1, busy1} !== 2'b10 || if_rdata1 !== 32'h0050_0093) $display("FAIL single_ret: got %b data %h want 10 00500093", {if_rvalid1, busy1}, if_rdata1); else n_pass++;
    @(negedge clk); #1;
    n_total++; if (if_rvalid1 !== 1'b0 || if_rdata1 !== 32'h0050_0093) $display("FAIL single_hold: got %b data %h want 0 00500093", if_rvalid1, if_rdata1); else n_pass++;
    drain(8);
  endtask

  task automatic test_contention();
    logic exp_ls [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int gi = 0;
    int last = -1;
    int pc = -1;
    logic pls = 1'b0;
    logic [31:0] pa = '0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if_req = (gi < 10); ls_req = (gi < 10);
      if_addr = $urandom; ls_addr = $urandom;
      #1;
      n_total++; if ({if_rvalid1, ls_rvalid1} !== {(pc == c) && !pls, (pc == c) && pls}) $display("FAIL cont_rvalid c=%0d: got %b want %b", c, {if_rvalid1, ls_rvalid1}, {(pc == c) && !pls, (pc == c) && pls}); else n_pass++;
      if (pc == c) begin
        n_total++; if ((pls ? ls_rdata1 : if_rdata1) !== rom_word(pa)) $display("FAIL cont_rdata c=%0d: got %h want %h", c, (pls ? ls_rdata1 : if_rdata1), rom_word(pa)); else n_pass++;
        pc = -1;
      end
      if ((if_gnt1 || ls_gnt1) && gi < 10) begin
        n_total++; if ({if_gnt1, ls_gnt1} !== {!exp_ls[gi], exp_ls[gi]}) $display("FAIL cont_order g=%0d: got if/ls %b want %b", gi, {if_gnt1, ls_gnt1}, {!exp_ls[gi], exp_ls[gi]}); else n_pass++;
        if (gi > 0) begin
          n_total++; if (c - last != 3) $display("FAIL cont_spacing g=%0d: got %0d want 3", gi, c - last); else n_pass++;
        end
        pls = ls_gnt1; pa = ls_gnt1 ? ls_addr : if_addr; pc = c + 3; last = c; gi++;
      end
    end
    n_total++; if (gi != 10) $display("FAIL cont_count: got %0d want 10", gi); else n_pass++;
    drain(8);
  endtask

  task automatic test_flush();
    logic [31:0] a [5];
    for (int i = 0; i < 5; i++) a[i] = $urandom;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      idle_in();
      case (c)
        0:  begin if_req = 1'b1; if_addr = a[0]; end
        4:  begin if_req = 1'b1; if_addr = a[1]; end
        6:  if_flush = 1'b1;
        7:  begin if_req = 1'b1; if_addr = a[2]; end
        11: begin ls_req = 1'b1; ls_addr = a[3]; end
        13: if_flush = 1'b1;
        15: begin if_req = 1'b1; if_addr = a[4]; if_flush = 1'b1; end
        default: ;
      endcase
      #1;
      case (c)
        0, 4: begin
          n_total++; if (if_gnt1 !== 1'b1) $display("FAIL flush_gnt c=%0d: got %b want 1", c, if_gnt1); else n_pass++;
        end
        3: begin
          n_total++; if (if_rvalid1 !== 1'b1 || if_rdata1 !== rom_word(a[0])) $display("FAIL flush_pre: got %b %h want 1 %h", if_rvalid1, if_rdata1, rom_word(a[0])); else n_pass++;
        end
        5, 6, 8, 9: begin
          n_total++; if (if_rvalid1 !== 1'b0) $display("FAIL flush_quiet c=%0d: got %b want 0", c, if_rvalid1); else n_pass++;
        end
        7: begin
          n_total++; if ({if_gnt1, if_rvalid1} !== 2'b10 || if_rdata1 !== rom_word(a[0])) $display("FAIL flush_killed: got %b %h want 10 %h", {if_gnt1, if_rvalid1}, if_rdata1, rom_word(a[0])); else n_pass++;
        end
        10: begin
          n_total++; if (if_rvalid1 !== 1'b1 || if_rdata1 !== rom_word(a[2])) $display("FAIL flush_after: got %b %h want 1 %h", if_rvalid1, if_rdata1, rom_word(a[2])); else n_pass++;
        end
        14: begin
          n_total++; if (ls_rvalid1 !== 1'b1 || ls_rdata1 !== rom_word(a[3])) $display("FAIL flush_ls_unaffected: got %b %h want 1 %h", ls_rvalid1, ls_rdata1, rom_word(a[3])); else n_pass++;
        end
        15: begin
          n_total++; if (if_gnt1 !== 1'b1) $display("FAIL flush_same_gnt: got %b want 1", if_gnt1); else n_pass++;
        end
        18: begin
          n_total++; if (if_rvalid1 !== 1'b1 || if_rdata1 !== rom_word(a[4])) $display("FAIL flush_same_cycle: got %b %h want 1 %h", if_rvalid1, if_rdata1, rom_word(a[4])); else n_pass++;
        end
        default: ;
      endcase
    end
    drain(8);
  endtask

  task automatic test_latency();
    logic [31:0] w0 = rom_word(32'h100);
    logic [31:0] w1 = rom_word(32'h204);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      idle_in();
      if (c == 0) begin ls_req = 1'b1; ls_addr = 32'h100; end
      if (c == 5) begin if_req = 1'b1; if_addr = 32'h204; end
      #1;
      case (c)
        0: begin
          n_total++; if ({ls_gnt3, if_gnt3} !== 2'b10) $display("FAIL lat_gnt: got %b want 10", {ls_gnt3, if_gnt3}); else n_pass++;
        end
        1: begin
          n_total++; if (rom_en3 !== 1'b1 || rom_addr3 !== 32'h100) $display("FAIL lat_issue: got %b %h want 1 00000100", rom_en3, rom_addr3); else n_pass++;
        end
        2, 3: begin
          n_total++; if ({rom_en3, busy3, ls_rvalid3} !== 3'b010) $display("FAIL lat_wait c=%0d: got %b want 010", c, {rom_en3, busy3, ls_rvalid3}); else n_pass++;
        end
        4: begin
          n_total++; if ({busy3, ls_rvalid3} !== 2'b10 || rom_data3 !== w0) $display("FAIL lat_capture: got %b %h want 10 %h", {busy3, ls_rvalid3}, rom_data3, w0); else n_pass++;
        end
        5: begin
          n_total++; if ({ls_rvalid3, if_gnt3} !== 2'b11 || ls_rdata3 !== w0) $display("FAIL lat_ret: got %b %h want 11 %h", {ls_rvalid3, if_gnt3}, ls_rdata3, w0); else n_pass++;
        end
        6, 7, 8, 9: begin
          n_total++; if ({ls_rvalid3, if_rvalid3} !== 2'b00 || ls_rdata3 !== w0) $display("FAIL lat_hold c=%0d: got %b %h want 00 %h", c, {ls_rvalid3, if_rvalid3}, ls_rdata3, w0); else n_pass++;
        end
        10: begin
          n_total++; if (if_rvalid3 !== 1'b1 || if_rdata3 !== w1 || ls_rdata3 !== w0) $display("FAIL lat_if_ret: got %b %h ls %h want 1 %h ls %h", if_rvalid3, if_rdata3, ls_rdata3, w1, w0); else n_pass++;
        end
        default: ;
      endcase
    end
    drain(8);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      idle_in();
      if (c == 0) begin if_req = 1'b1; if_addr = 32'h300; end
      if (c == 2) rst = 1'b1;
      if (c == 4) begin rst = 1'b0; ls_req = 1'b1; ls_addr = 32'h400; end
      #1;
      if (c == 2 || c == 3) begin
        n_total++; if ({rom_addr1, if_rdata1, ls_rdata1, rom_en1, busy1, if_rvalid1, ls_rvalid1} !== 100'b0) $display("FAIL rstmid_out1 c=%0d: got %h want 0", c, {rom_addr1, if_rdata1, ls_rdata1, rom_en1, busy1, if_rvalid1, ls_rvalid1}); else n_pass++;
        n_total++; if ({rom_addr3, if_rdata3, ls_rdata3, rom_en3, busy3, if_rvalid3, ls_rvalid3} !== 100'b0) $display("FAIL rstmid_out3 c=%0d: got %h want 0", c, {rom_addr3, if_rdata3, ls_rdata3, rom_en3, busy3, if_rvalid3, ls_rvalid3}); else n_pass++;
      end
      if (c == 4) begin
        n_total++; if ({ls_gnt1, ls_gnt3} !== 2'b11) $display("FAIL rstmid_first_gnt: got %b want 11", {ls_gnt1, ls_gnt3}); else n_pass++;
      end
      if (c >= 4) begin
        n_total++; if ({if_rvalid1, if_rvalid3} !== 2'b00) $display("FAIL rstmid_no_rvalid c=%0d: got %b want 00", c, {if_rvalid1, if_rvalid3}); else n_pass++;
      end
      if (c == 7) begin
        n_total++; if (ls_rvalid1 !== 1'b1 || ls_rdata1 !== rom_word(32'h400)) $display("FAIL rstmid_ls_ret: got %b %h want 1 %h", ls_rvalid1, ls_rdata1, rom_word(32'h400)); else n_pass++;
      end
    end
    drain(8);
  endtask

  // Transaction-level reference for the latency-1 instance: the port is free again
  // LAT+2 cycles after an acceptance, the owner's word returns at that same cycle,
  // and a flush anywhere strictly between acceptance and return drops a fetch.
  task automatic test_random();
    int free_at = 0;
    int starve = 0;
    int acc = -1;
    int ret = -1;
    logic p_ls = 1'b0;
    logic killed = 1'b0;
    logic [31:0] p_a = '0;
    logic [31:0] m_if = '0;
    logic [31:0] m_ls = '0;
    logic e_ig, e_lg, e_irv, e_lrv;
    rst = 1'b1; idle_in();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if_req   = ($urandom_range(0, 3) != 0);
      ls_req   = ($urandom_range(0, 1) != 0);
      if_flush = ($urandom_range(0, 5) == 0);
      if_addr  = $urandom;
      ls_addr  = $urandom;
      #1;
      e_irv = 1'b0; e_lrv = 1'b0;
      if (ret == c) begin
        if (p_ls) begin
          e_lrv = 1'b1; m_ls = rom_word(p_a);
        end else if (!killed) begin
          e_irv = 1'b1; m_if = rom_word(p_a);
        end
        ret = -1;
      end
      if (ret > c && c > acc && !p_ls && if_flush) killed = 1'b1;
      e_ig = 1'b0; e_lg = 1'b0;
      if (c >= free_at) begin
        if (if_req && ls_req) begin
          if (starve >= LIM) e_ig = 1'b1; else e_lg = 1'b1;
        end else begin
          e_ig = if_req; e_lg = ls_req;
        end
        if (!if_req || e_ig) starve = 0;
        else if (e_lg) starve++;
        if (e_ig || e_lg) begin
          acc = c; ret = c + 3; free_at = c + 3;
          p_ls = e_lg; p_a = e_lg ? ls_addr : if_addr; killed = 1'b0;
        end
      end
      n_total++; if ({if_gnt1, ls_gnt1} !== {e_ig, e_lg}) $display("FAIL rand_gnt c=%0d: got %b want %b", c, {if_gnt1, ls_gnt1}, {e_ig, e_lg}); else n_pass++;
      n_total++; if ({if_rvalid1, ls_rvalid1} !== {e_irv, e_lrv}) $display("FAIL rand_rvalid c=%0d: got %b want %b", c, {if_rvalid1, ls_rvalid1}, {e_irv, e_lrv}); else n_pass++;
      n_total++; if (if_rdata1 !== m_if) $display("FAIL rand_if_rdata c=%0d: got %h want %h", c, if_rdata1, m_if); else n_pass++;
      n_total++; if (ls_rdata1 !== m_ls) $display("FAIL rand_ls_rdata c=%0d: got %h want %h", c, ls_rdata1, m_ls); else n_pass++;
    end
    drain(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0; if_addr = '0; ls_addr = '0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_flush();
    test_latency();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single instruction-ROM read port between two requesters:
  - the instruction-fetch path (IF);
  - a load path (LS) reading constant data out of ROM.
- Sits between the fetch stage / load-store unit and the external ROM pins (rom_addr, rom_en, rom_data).
- Sequences each access through a fixed-latency ROM and routes the returned word to the owning requester.
- Flushing a fetch on branch redirect discards a stale instruction word.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, ROM data width.
- ROM_LATENCY, 1, cycles from the rom_en cycle to valid rom_data; legal range 1..7.
- STARVE_LIMIT, 4, maximum consecutive LS grants while if_req is held before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_flush  in  1  drop any previously accepted, not-yet-returned fetch.
- if_rvalid  out  1  one-cycle pulse: if_rdata is new.
- if_rdata  out  DATA_W  fetched word; holds until the next IF return.
- ls_req  in  1  load request.
- ls_addr  in  ADDR_W  load address.
- ls_gnt  out  1  load request accepted this cycle.
- ls_rvalid  out  1  one-cycle pulse: ls_rdata is new.
- ls_rdata  out  DATA_W  loaded word; holds until the next LS return.
- rom_addr  out  ADDR_W  ROM address, registered.
- rom_en  out  1  ROM read strobe.
- rom_data  in  DATA_W  ROM read data.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (asynchronous, any state, mid-access included):
  - state goes to IDLE;
  - rom_addr, rom_en, if_rdata, ls_rdata, if_rvalid, ls_rvalid, the starvation counter and the owner/kill flags all go to 0;
  - an in-flight response is never delivered.
- Only one access is outstanding at a time.
- FSM states:
  - IDLE: the arbiter evaluates requests. if_gnt and ls_gnt are combinational, active only in IDLE, mutually exclusive.
    - A request is accepted in cycle T when req and gnt are both 1 in T.
    - On acceptance, the address is latched into rom_addr, the owner is recorded, and the FSM goes to ISSUE.
    - With no request, the FSM stays in IDLE.
  - ISSUE (cycle T+1): rom_en=1 for exactly this cycle. Next state is WAIT.
  - WAIT: counts ROM_LATENCY cycles. rom_data is valid in cycle T+1+ROM_LATENCY.
    - In that cycle, rom_data is captured into the owner's rdata register, and the FSM returns to IDLE.
- Response: the owner's rvalid pulses high in cycle T+2+ROM_LATENCY.
  - A new acceptance may occur in that same cycle (back-to-back).
  - Peak throughput is one access per ROM_LATENCY+2 cycles.
- Arbitration:
  - LS has priority by default.
  - The starvation counter increments on every LS acceptance while if_req=1.
  - The counter clears on an IF acceptance, or in any IDLE cycle with if_req=0.
  - When the counter equals STARVE_LIMIT and both requesters are requesting, IF wins.
  - When only one requester is requesting, it wins.
- Requesters are not required to hold req/addr while ungranted; the arbiter samples them only in IDLE.
- Flush:
  - if_flush=1 while the owner is IF and the state is ISSUE or WAIT sets the kill flag.
  - if_flush=1 in the capture cycle also sets the kill flag.
  - With kill set, the capture still completes but if_rdata is not updated and if_rvalid is not pulsed.
  - A fetch accepted in the same cycle as if_flush is not killed.
  - if_flush has no effect on LS ownership or in IDLE.
- rom_addr holds its last value outside ISSUE. rom_en is 0 outside ISSUE.

Test Plan:
- Single fetch: reset, ROM_LATENCY=1, if_req with if_addr=0x0000_0010 in cycle 2.
  - Required: if_gnt in cycle 2, rom_en in cycle 3 with rom_addr=0x10, rom_data=0x00500093 in cycle 4, if_rvalid in cycle 5 with if_rdata=0x00500093, busy high in cycles 3-4.
- Contention: if_req and ls_req held high continuously, STARVE_LIMIT=4.
  - Required: grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF, with gnt pulses spaced 3 cycles apart; each rdata matches its own address.
- Flush: fetch accepted at T, if_flush=1 at T+2.
  - Required: no if_rvalid and if_rdata unchanged.
  - A fetch accepted at T+3 with if_flush=0 then returns normally at T+6.
- Latency sweep: ROM_LATENCY=3, LS read of 0x100.
  - Required: rom_en at T+1, capture at T+4, ls_rvalid at T+5; ls_rdata holds the value through a subsequent IF access.
- Reset mid-access: rst asserted during WAIT.
  - Required: all outputs 0 immediately, no rvalid after release, and the first request after release is granted in its first IDLE cycle.
